pio_clkdiv: RTL and testbench
=============================

Name: pio_clkdiv

Overview:
- Multi-channel fractional clock divider; the successor to the single-channel divider.
- One instance per PIO block produces one clock-enable per state machine.
- Each channel divides `clk` by a 16.8 fixed-point divisor.
- Each channel has its own enable and phase restart, and outputs a one-cycle tick (`pen`) plus an approximately 50% duty divided clock (`pclk`) for debug/pins.

Parameters:
- NCH, 4, number of independent channels.
- INT_W, 16, integer divisor width.
- FRAC_W, 8, fractional divisor width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- div  in  NCH*(INT_W+FRAC_W)  per-channel divisor.
  - Channel k occupies bits [k*(INT_W+FRAC_W) +: INT_W+FRAC_W].
  - Upper INT_W bits are the integer part I; lower FRAC_W bits are the fraction F.
- en  in  NCH  per-channel run enable, level.
- restart  in  NCH  per-channel phase restart, single-cycle pulse.
- pen  out  NCH  per-channel tick, one `clk` cycle wide, registered.
- pclk  out  NCH  per-channel divided clock, registered.

Behaviour:
- Clock and reset:
  - Single clock `clk`. `reset` is asynchronous and active-high.
  - On reset, all state clears immediately, with no clock edge needed: cnt=0, facc=0, pen=0, pclk=0.
- Per-channel state:
  - cnt, width INT_W+1, a down-counter.
  - facc, width FRAC_W, the fractional accumulator.
- Effective integer part: Ieff = I, except I==0 is treated as 2^INT_W, giving the maximum division.
- Internal tick: tick = en & ~restart & (cnt==0).
- Per-cycle update, in priority order:
  1. restart=1: cnt<=0, facc<=0, pen<=0, pclk<=0. This holds regardless of `en`.
  2. en=0: cnt and facc hold, pen<=0, pclk<=0.
  3. tick:
     - {c,f} = facc + F (FRAC_W+1 bits); facc<=f.
     - cnt <= Ieff - 1 + c.
     - pen<=1.
  4. Otherwise: cnt<=cnt-1, pen<=0.
- Period and average rate:
  - Period between ticks is Ieff + c cycles.
  - Long-run average period is exactly Ieff + F/2^FRAC_W.
- pclk:
  - While en=1 and no restart: pclk <= (cnt_next >= (Ieff>>1)), where cnt_next is the value cnt is loaded with this cycle.
  - I=1: pclk stays 1. I=2: 1 high / 1 low. I=4: 2 high / 2 low.
  - pen is the authoritative timing signal; pclk is informative.
- Latency:
  - pen rises on the cycle after cnt==0 is sampled.
  - First pen after reset or restart occurs 1 cycle after the first cycle with en=1, so the channel starts immediately.
- Divisor changes:
  - `div` is sampled only at tick (reload) and in the pclk compare.
  - Mid-period changes to I/F affect the next period, not the current count.
  - Exception: the pclk threshold uses the live Ieff.
- en low mid-period:
  - The phase freezes.
  - Re-enable resumes the count from the frozen cnt and facc.
- Simultaneous restart on several channels:
  - Their pens align on the next enabled cycle.
  - They stay aligned if the divisors are equal.
- I=1, F=0: pen is high every cycle while enabled.
- I=1, F>0: occasional 2-cycle gaps, per the carry rule.
- Channels are fully independent; no shared state.

Decomposition:
- Shared package pio_pkg:
  - Constants PIO_DIV_INT_W=16 and PIO_DIV_FRAC_W=8.
  - Divisor struct/typedef {int, frac}.
  - A helper for Ieff (zero maps to max).
- One sub-module, pio_clkdiv_ch:
  - Single channel containing cnt, facc and the output registers.
  - pio_clkdiv is a generate loop over NCH that slices `div`, `en` and `restart`.

Test Plan:
- Assert reset mid-run without a clock edge -> pen=0 and pclk=0 immediately. Release, ch0 I=4 F=0 en=1 -> pen on cycles 1,5,9,13 after en; pclk pattern 1,1,0,0 repeating.
- ch1 I=2 F=0x80 -> pen gaps 2,3,2,3,…; exactly 10 pens in 25 cycles; facc returns to 0 every 2 ticks.
- ch2 I=1 F=0 -> pen high every enabled cycle; pclk constant 1. Then I=1 F=0x40 -> one extra idle cycle every 4 ticks.
- ch3 I=0 F=0 -> pen spacing 65536 cycles.
- Change I from 4 to 8 mid-period -> current period still ends at 4; next gap is 8.
- ch0 I=3 and ch1 I=3 running with different phases; pulse restart on both in the same cycle -> pens coincide from then on. Drop en for 5 cycles mid-period -> pen stops and pclk=0; on resume the next pen arrives after the remaining count, not a full period.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the PIO clock-divider family: divisor field widths,
// the packed divisor layout, and the effective-integer-part helper.
package pio_pkg;

    localparam int PIO_DIV_INT_W  = 16;
    localparam int PIO_DIV_FRAC_W = 8;

    // One channel's divisor word: integer part in the upper bits, fraction below.
    typedef struct packed {
        logic [PIO_DIV_INT_W-1:0]  ipart;
        logic [PIO_DIV_FRAC_W-1:0] fpart;
    } pio_div_t;

    // An integer part of zero selects the largest division, 2^INT_W.
    function automatic logic [PIO_DIV_INT_W:0] pio_ieff(input logic [PIO_DIV_INT_W-1:0] ipart);
        return (ipart == '0) ? {1'b1, {PIO_DIV_INT_W{1'b0}}} : {1'b0, ipart};
    endfunction

endpackage

// File: rtl/pio_clkdiv_ch.sv
// One fractional divider channel: a down-counter reloaded at each tick with
// Ieff-1 plus the carry out of a fractional accumulator, so the long-run
// period is Ieff + F/2^FRAC_W cycles.
module pio_clkdiv_ch
    import pio_pkg::*;
#(
    parameter int INT_W  = PIO_DIV_INT_W,
    parameter int FRAC_W = PIO_DIV_FRAC_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INT_W+FRAC_W-1:0] div,
    input  logic                    en,
    input  logic                    restart,
    output logic                    pen,
    output logic                    pclk
);

    logic [INT_W-1:0]  i_part;
    logic [FRAC_W-1:0] f_part;
    logic [INT_W:0]    ieff;
    logic [INT_W:0]    cnt_reg, cnt_next;
    logic [FRAC_W-1:0] facc_reg, facc_next;
    logic [FRAC_W:0]   fsum;
    logic              tick;
    logic              pen_reg, pen_next;
    logic              pclk_reg, pclk_next;

    assign i_part = div[FRAC_W +: INT_W];
    assign f_part = div[FRAC_W-1:0];

    // Next-state selection: restart beats disable, disable beats counting.
    always_comb begin
        ieff      = (i_part == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, i_part};
        fsum      = {1'b0, facc_reg} + {1'b0, f_part};
        tick      = en & ~restart & (cnt_reg == '0);
        cnt_next  = cnt_reg;
        facc_next = facc_reg;
        pen_next  = 1'b0;
        pclk_next = 1'b0;
        if (restart) begin
            cnt_next  = '0;
            facc_next = '0;
        end else if (en) begin
            if (tick) begin
                facc_next = fsum[FRAC_W-1:0];
                cnt_next  = ieff - (INT_W+1)'(1) + (INT_W+1)'(fsum[FRAC_W]);
                pen_next  = 1'b1;
            end else begin
                cnt_next  = cnt_reg - (INT_W+1)'(1);
            end
            // Threshold follows the live divisor so pclk tracks edits promptly.
            pclk_next = (cnt_next >= (ieff >> 1));
        end
    end

    // Channel state and registered outputs; reset clears without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg  <= '0;
            facc_reg <= '0;
            pen_reg  <= 1'b0;
            pclk_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            facc_reg <= facc_next;
            pen_reg  <= pen_next;
            pclk_reg <= pclk_next;
        end
    end

    assign pen  = pen_reg;
    assign pclk = pclk_reg;

endmodule

// File: rtl/pio_clkdiv.sv
// Multi-channel fractional clock divider: one independent channel per PIO
// state machine, each with its own divisor slice, enable and restart.
module pio_clkdiv
    import pio_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int INT_W  = PIO_DIV_INT_W,
    parameter int FRAC_W = PIO_DIV_FRAC_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NCH*(INT_W+FRAC_W)-1:0]   div,
    input  logic [NCH-1:0]                  en,
    input  logic [NCH-1:0]                  restart,
    output logic [NCH-1:0]                  pen,
    output logic [NCH-1:0]                  pclk
);

    localparam int DW = INT_W + FRAC_W;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            pio_clkdiv_ch #(
                .INT_W  (INT_W),
                .FRAC_W (FRAC_W)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .div     (div[gi*DW +: DW]),
                .en      (en[gi]),
                .restart (restart[gi]),
                .pen     (pen[gi]),
                .pclk    (pclk[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pio_clkdiv.sv
// Bench for pio_clkdiv: expected pen cycle stamps are derived from the
// period rule (gap = Ieff + carry) and queued per channel; a negedge monitor
// pops and compares them as pens appear. pclk and freeze behaviour are
// checked directly at chosen cycles.
module tb_pio_clkdiv;
    import pio_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = PIO_DIV_INT_W + PIO_DIV_FRAC_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NCH*DW-1:0] div = '0;
    logic [NCH-1:0]    en = '0;
    logic [NCH-1:0]    restart = '0;
    logic [NCH-1:0]    pen;
    logic [NCH-1:0]    pclk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int exp_q [NCH][$];
    int win_lo [NCH];
    int win_hi [NCH];
    int pcount [NCH];

    pio_clkdiv #(.NCH(NCH)) dut (
        .clk     (clk),
        .reset   (reset),
        .div     (div),
        .en      (en),
        .restart (restart),
        .pen     (pen),
        .pclk    (pclk)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Scoreboard monitor: every pen inside a channel's window must match the
    // next queued stamp.
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (!reset && pen[k] && cyc >= win_lo[k] && cyc <= win_hi[k]) begin
                pcount[k]++;
                if (exp_q[k].size() == 0)
                    chk($sformatf("pen_extra_ch%0d", k), cyc, -1);
                else
                    chk($sformatf("pen_time_ch%0d", k), cyc, exp_q[k].pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_div(input int ch, input logic [15:0] ip, input logic [7:0] fp);
        pio_div_t d;
        d.ipart = ip;
        d.fpart = fp;
        div[ch*DW +: DW] = d;
    endtask

    task automatic arm(input int ch, input int lo, input int hi);
        win_lo[ch] = lo;
        win_hi[ch] = hi;
    endtask

    // Expected tick stamps from a fresh phase: each gap is Ieff plus the
    // carry produced when F is added to the running fraction.
    task automatic push_pens(input int ch, input int first, input int hi,
                             input logic [15:0] ip, input logic [7:0] fp);
        int t;
        int facc;
        int ie;
        t    = first;
        facc = 0;
        ie   = int'(pio_ieff(ip));
        while (t <= hi) begin
            exp_q[ch].push_back(t);
            facc = facc + int'(fp);
            t    = t + ie + (facc >> 8);
            facc = facc & 255;
        end
    endtask

    task automatic drain(input int ch);
        chk($sformatf("missing_ch%0d", ch), exp_q[ch].size(), 0);
    endtask

    initial begin
        int n;
        int r;
        int c0;
        for (int k = 0; k < NCH; k++) begin
            win_lo[k] = 1;
            win_hi[k] = 0;
            pcount[k] = 0;
        end

        // Reset state
        step(3);
        chk("rst_pen", pen, 0);
        chk("rst_pclk", pclk, 0);
        reset = 1'b0;
        step(1);

        // Asynchronous reset while a pen is high
        set_div(0, 16'd4, 8'h00);
        en[0] = 1'b1;
        step(1);
        chk("pre_rst_pen", pen[0], 1);
        reset = 1'b1;
        #1;
        chk("async_pen", pen, 0);
        chk("async_pclk", pclk, 0);
        en = '0;
        #1;
        reset = 1'b0;
        step(1);

        // ch0 I=4: pens every 4 cycles, pclk 1,1,0,0
        n = cyc;
        arm(0, n + 1, n + 13);
        push_pens(0, n + 1, n + 13, 16'd4, 8'h00);
        en[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("pclk_i4", pclk[0], (((i - 1) % 4) < 2) ? 1 : 0);
        end
        step(6);
        drain(0);
        en[0] = 1'b0;

        // ch1 I=2 F=0x80: gaps 2,3,... and 10 pens in 25 cycles
        set_div(1, 16'd2, 8'h80);
        n = cyc;
        arm(1, n + 1, n + 25);
        push_pens(1, n + 1, n + 25, 16'd2, 8'h80);
        c0 = pcount[1];
        en[1] = 1'b1;
        step(26);
        chk("pens_in_25", pcount[1] - c0, 10);
        drain(1);
        en[1] = 1'b0;

        // ch2 I=1 F=0: pen every cycle, pclk stuck high
        set_div(2, 16'd1, 8'h00);
        n = cyc;
        arm(2, n + 1, n + 8);
        push_pens(2, n + 1, n + 8, 16'd1, 8'h00);
        en[2] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            chk("pclk_i1", pclk[2], 1);
        end
        step(1);
        drain(2);

        // ch2 I=1 F=0x40 after a restart: extra idle cycle every 4 ticks
        en[2] = 1'b0;
        restart[2] = 1'b1;
        set_div(2, 16'd1, 8'h40);
        step(1);
        restart[2] = 1'b0;
        en[2] = 1'b1;
        n = cyc;
        arm(2, n + 1, n + 16);
        push_pens(2, n + 1, n + 16, 16'd1, 8'h40);
        step(17);
        drain(2);
        en[2] = 1'b0;

        // ch0 I changed 4 -> 8 mid-period: current period still 4, then 8
        restart[0] = 1'b1;
        set_div(0, 16'd4, 8'h00);
        step(1);
        restart[0] = 1'b0;
        en[0] = 1'b1;
        n = cyc;
        arm(0, n + 1, n + 21);
        exp_q[0].push_back(n + 1);
        exp_q[0].push_back(n + 5);
        exp_q[0].push_back(n + 13);
        exp_q[0].push_back(n + 21);
        step(3);
        set_div(0, 16'd8, 8'h00);
        step(19);
        drain(0);
        en[0] = 1'b0;

        // ch0/ch1 I=3 at different phases, common restart, then ch0 freeze
        set_div(0, 16'd3, 8'h00);
        set_div(1, 16'd3, 8'h00);
        restart[1:0] = 2'b11;
        step(1);
        restart[1:0] = 2'b00;
        en[0] = 1'b1;
        step(1);
        en[1] = 1'b1;
        step(4);
        restart[1:0] = 2'b11;
        step(1);
        restart[1:0] = 2'b00;
        r = cyc;
        chk("restart_pen", pen[1:0], 0);
        chk("restart_pclk", pclk[1:0], 0);
        arm(0, r + 1, r + 19);
        arm(1, r + 1, r + 19);
        push_pens(1, r + 1, r + 19, 16'd3, 8'h00);
        exp_q[0].push_back(r + 1);
        exp_q[0].push_back(r + 4);
        exp_q[0].push_back(r + 7);
        exp_q[0].push_back(r + 15);
        exp_q[0].push_back(r + 18);
        step(8);
        en[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("freeze_pen", pen[0], 0);
            chk("freeze_pclk", pclk[0], 0);
        end
        en[0] = 1'b1;
        step(7);
        drain(0);
        drain(1);
        en[1:0] = 2'b00;

        // ch3 I=0: maximum division, pens 65536 cycles apart
        set_div(3, 16'd0, 8'h00);
        n = cyc;
        arm(3, n + 1, n + 65537);
        push_pens(3, n + 1, n + 65537, 16'd0, 8'h00);
        en[3] = 1'b1;
        step(1);
        chk("pclk_max_start", pclk[3], 1);
        step(32767);
        chk("pclk_max_hi_edge", pclk[3], 1);
        step(1);
        chk("pclk_max_lo_edge", pclk[3], 0);
        step(32769);
        drain(3);
        en[3] = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
